uartin: RTL and testbench

//  8N1 UART receiver, the counterpart to uartout. Oversamples serial rx at

---
 rtl/uart_pkg.sv | 14 +
 rtl/uartin_bitcnt.sv | 32 +++
 rtl/uartin.sv | 137 +++++++++++++
 tb/tb_uartin.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver (uartin) and the transmitter (uartout).
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } uartin_state_t;

endpackage

// File: rtl/uartin_bitcnt.sv
// Bit-period divider for the UART receiver. It counts clocks since the last clear
// and emits a sample strobe at mid-bit (half mode) or after one full bit period.
module uartin_bitcnt #(
  parameter int CDIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_half,
  output logic o_strobe
);

  localparam int CW = $clog2(CDIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(CDIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CDIV - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_last;

  assign w_last   = i_half ? HALF_LAST : FULL_LAST;
  assign o_strobe = !i_clear && (r_cnt == w_last);

  // The counter restarts on every strobe, so each following sample lands one full bit later.
  always_ff @(posedge clk) begin
    if (rst || i_clear || o_strobe) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uartin.sv
// 8N1 UART receiver (MSB first) with a one-entry output buffer and an active-low
// valid/ready handshake. Define UARTIN_RXSYNC_EN to add a 2-flop rx synchroniser.
module uartin
  import uart_pkg::*;
#(
  parameter int CDIV = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      n_valid,
  input  logic                      n_ready,
  output logic                      frame_err,
  output logic                      overrun
);

  logic w_rxS;

`ifdef UARTIN_RXSYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxS = r_sync2;
`else
  assign w_rxS = rx;
`endif

  uartin_state_t r_state;
  uartin_state_t w_nextState;

  logic [2:0]                r_bitIdx;
  logic [UART_DATA_BITS-1:0] r_shreg;
  logic [UART_DATA_BITS-1:0] r_data;
  logic                      r_nValid;
  logic                      r_frameErr;
  logic                      r_overrun;

  logic w_strobe;
  logic w_clear;
  logic w_half;
  logic w_sampleBit;
  logic w_stopOk;
  logic w_stopBad;
  logic w_take;

  assign w_clear = (r_state == IDLE) || (r_state == BRK);
  assign w_half  = (r_state == START);

  uartin_bitcnt #(
    .CDIV(CDIV)
  ) u_bitcnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_half  (w_half),
    .o_strobe(w_strobe)
  );

  assign w_sampleBit = w_strobe && (r_state == DATA);
  assign w_stopOk    = w_strobe && (r_state == STOP) && w_rxS;
  assign w_stopBad   = w_strobe && (r_state == STOP) && !w_rxS;
  assign w_take      = !r_nValid && !n_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (!w_rxS) w_nextState = START;
      START:   if (w_strobe) w_nextState = w_rxS ? IDLE : DATA;
      DATA:    if (w_strobe && (r_bitIdx == 3'd0)) w_nextState = STOP;
      STOP:    if (w_strobe) w_nextState = w_rxS ? IDLE : BRK;
      // A held-low line after a bad stop bit must not be mistaken for a new start bit.
      BRK:     if (w_rxS) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bitIdx   <= 3'd0;
      r_shreg    <= '0;
      r_data     <= '0;
      r_nValid   <= 1'b1;
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_frameErr <= w_stopBad;
      r_overrun  <= 1'b0;

      if (w_strobe && (r_state == START)) begin
        r_bitIdx <= 3'(UART_DATA_BITS - 1);
      end else if (w_sampleBit && (r_bitIdx != 3'd0)) begin
        r_bitIdx <= r_bitIdx - 3'd1;
      end

      if (w_sampleBit) begin
        r_shreg <= {r_shreg[UART_DATA_BITS-2:0], w_rxS};
      end

      // A buffer being drained on the same edge counts as free for the new byte.
      if (w_stopOk) begin
        if (r_nValid || w_take) begin
          r_data   <= r_shreg;
          r_nValid <= 1'b0;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_take) begin
        r_nValid <= 1'b1;
      end
    end
  end

  assign data      = r_data;
  assign n_valid   = r_nValid;
  assign frame_err = r_frameErr;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uartin.sv
// Self-checking bench for uartin: an event-level model predicts the output buffer
// from the frames the bench sends, plus literal checks at hand-computed cycles.
module tb_uartin;

  localparam int CDIV = 2;
  localparam int H    = CDIV / 2;
`ifdef UARTIN_RXSYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       n_ready = 1'b1;
  logic [7:0] data;
  logic       n_valid;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;

  uartin #(
    .CDIV(CDIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .n_valid  (n_valid),
    .n_ready  (n_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  typedef struct {
    int         at;
    bit         isFe;
    logic [7:0] b;
  } ev_t;

  ev_t evQ[$];

  int         cyc = 0;
  int         nCompared = 0;
  int         nMismatch = 0;
  logic       expNValid = 1'b1;
  logic [7:0] expData = 8'h00;
  logic       expFe = 1'b0;
  logic       expOv = 1'b0;

  function automatic void checkOutput(input string name, input logic [7:0] actual,
                                      input logic [7:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endfunction

  // Each frame's outcome is known when it is sent; apply it at its stop-sample edge.
  always @(posedge clk) begin : model
    bit  take;
    bit  hit;
    ev_t ev;
    cyc++;
    if (rst) begin
      expNValid = 1'b1;
      expData   = 8'h00;
      expFe     = 1'b0;
      expOv     = 1'b0;
      evQ.delete();
    end else begin
      take  = !expNValid && !n_ready;
      hit   = 1'b0;
      expFe = 1'b0;
      expOv = 1'b0;
      if (evQ.size() > 0) begin
        if (evQ[0].at == cyc) begin
          ev  = evQ.pop_front();
          hit = 1'b1;
        end
      end
      if (hit && ev.isFe) begin
        expFe = 1'b1;
        if (take) expNValid = 1'b1;
      end else if (hit) begin
        if (expNValid || take) begin
          expData   = ev.b;
          expNValid = 1'b0;
        end else begin
          expOv = 1'b1;
        end
      end else if (take) begin
        expNValid = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    checkOutput("n_valid", 8'(n_valid), 8'(expNValid));
    checkOutput("data", data, expData);
    checkOutput("frame_err", 8'(frame_err), 8'(expFe));
    checkOutput("overrun", 8'(overrun), 8'(expOv));
  end

  // Drives one frame starting at a falling edge and pins the outputs just after the
  // stop-sample edge, which for CDIV=2 is 20 rising edges after the call (plus LAT).
  task automatic applyStimulus(input logic [7:0] b, input bit stopBit, input int brkLen,
                               input bit takeAtStop, input logic pinNv, input logic [7:0] pinData,
                               input logic pinFe, input logic pinOv);
    int  t0 = cyc;
    int  s  = t0 + 1 + H + 9 * CDIV + LAT;
    int  n  = 10 * CDIV + brkLen + LAT + 2;
    ev_t ev;
    ev.at   = s;
    ev.isFe = !stopBit;
    ev.b    = b;
    evQ.push_back(ev);
    for (int k = 0; k < n; k++) begin
      int slot = k / CDIV;
      if (cyc == t0 + 20 + LAT) begin
        checkOutput("pin n_valid", 8'(n_valid), 8'(pinNv));
        checkOutput("pin data", data, pinData);
        checkOutput("pin frame_err", 8'(frame_err), 8'(pinFe));
        checkOutput("pin overrun", 8'(overrun), 8'(pinOv));
      end
      if (slot == 0) rx = 1'b0;
      else if (slot <= 8) rx = b[8-slot];
      else if (slot == 9) rx = stopBit;
      else if (!stopBit && (k < 10 * CDIV + brkLen)) rx = 1'b0;
      else rx = 1'b1;
      n_ready = (takeAtStop && (cyc == s - 1)) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    n_ready = 1'b1;
  endtask

  task automatic pulseReady();
    n_ready = 1'b0;
    @(negedge clk);
    n_ready = 1'b1;
    checkOutput("n_valid after take", 8'(n_valid), 8'd1);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset n_valid", 8'(n_valid), 8'd1);
    checkOutput("reset data", data, 8'h00);
    checkOutput("reset frame_err", 8'(frame_err), 8'd0);
    checkOutput("reset overrun", 8'(overrun), 8'd0);

    applyStimulus(8'h53, 1'b1, 0, 1'b0, 1'b0, 8'h53, 1'b0, 1'b0);
    pulseReady();
    applyStimulus(8'h74, 1'b1, 0, 1'b0, 1'b0, 8'h74, 1'b0, 1'b0);
    pulseReady();

    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (6 + LAT) @(negedge clk);
    checkOutput("glitch n_valid", 8'(n_valid), 8'd1);
    applyStimulus(8'h5A, 1'b1, 0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0);
    pulseReady();

    applyStimulus(8'h41, 1'b0, 10, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0);
    applyStimulus(8'h42, 1'b1, 0, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0);
    pulseReady();

    applyStimulus(8'h31, 1'b1, 0, 1'b0, 1'b0, 8'h31, 1'b0, 1'b0);
    applyStimulus(8'h32, 1'b1, 0, 1'b0, 1'b0, 8'h31, 1'b0, 1'b1);
    pulseReady();
    applyStimulus(8'h31, 1'b1, 0, 1'b0, 1'b0, 8'h31, 1'b0, 1'b0);
    applyStimulus(8'h32, 1'b1, 0, 1'b1, 1'b0, 8'h32, 1'b0, 1'b0);
    pulseReady();

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
